// File: rtl/min_reduce_ctrl_pkg.sv
// Shared types and helpers for the streaming minimum-reduction controller.
package min_reduce_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Index width never drops below one bit, even for a single-element reduction.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/min_reduce_ctrl_if.sv
// Producer stream and consumer result handshakes of the min-reduction controller.
interface min_reduce_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_idx
    );
endinterface

// File: rtl/gt_uint_nbit.sv
// Unsigned strictly-greater-than comparator over the full operand width.
module gt_uint_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             gt_o
);
    assign gt_o = (a_i > b_i);
endmodule

// File: rtl/min_reduce_ctrl.sv
// Streams COUNT elements through one shared comparator and reports the minimum
// value together with the index of its first occurrence.
module min_reduce_ctrl
    import min_reduce_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned COUNT = 16,
    parameter int unsigned IDX_W = clog2_min1(COUNT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                clr,
    output logic                busy,
    min_reduce_ctrl_if.slave    bus
);
    localparam int unsigned CntW = IDX_W + 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  cur_min_q, cur_min_d;
    logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
    logic              gt;
    logic              accept;

    gt_uint_nbit #(
        .WIDTH (WIDTH)
    ) u_gt (
        .a_i  (cur_min_q),
        .b_i  (bus.in_data),
        .gt_o (gt)
    );

    assign bus.in_ready  = (state_q == StRun);
    assign bus.out_valid = (state_q == StDone);
    assign busy          = (state_q == StRun) || (state_q == StDone);
    assign bus.out_min   = cur_min_q;
    assign bus.out_idx   = cur_idx_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_min_d = cur_min_q;
        cur_idx_d = cur_idx_q;
        case (state_q)
            StRun: begin
                if (accept) begin
                    // First element seeds the running minimum; later ties keep the earlier index.
                    if (cnt_q == '0) begin
                        cur_min_d = bus.in_data;
                        cur_idx_d = '0;
                    end else if (gt) begin
                        cur_min_d = bus.in_data;
                        cur_idx_d = cnt_q[IDX_W-1:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(COUNT - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                // Unused encoding 3 behaves as idle.
                state_d = StIdle;
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
        endcase
        if (clr) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cur_min_q <= '0;
            cur_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_min_q <= cur_min_d;
            cur_idx_q <= cur_idx_d;
        end
    end

endmodule
